// File: rtl/aer_pkg.sv
// Shared types and helpers for the spike address-event (AER) encoder.
// aer_evt_t is the default-sized event record; the encoder datapath itself is parameterised.
package aer_pkg;

    localparam int unsigned AER_ADDR_W = 2;
    localparam int unsigned AER_TS_W   = 8;
    localparam int unsigned DROP_CNT_W = 8;

    typedef struct packed {
        logic [AER_ADDR_W-1:0] addr;
        logic [AER_TS_W-1:0]   ts;
    } aer_evt_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/aer_event_fifo.sv
// Synchronous show-ahead FIFO for AER events; the head word is visible whenever the FIFO is
// non-empty. Pointers carry one extra MSB so full and empty can be told apart.
module aer_event_fifo
    import aer_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 10
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [clog2(DEPTH):0]  level_o
);

    localparam int unsigned AW = clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_en;
    logic             pop_en;

    always_comb begin
        empty_o  = (wr_ptr_q == rd_ptr_q);
        full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        push_en  = push_i && !full_o;
        pop_en   = pop_i && !empty_o;
        wr_ptr_d = push_en ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop_en ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        level_o  = wr_ptr_q - rd_ptr_q;
        // Storage is not reset, so the head is forced to zero while empty.
        head_o   = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/spike_aer_encoder.sv
// Samples neuron spikes each enabled timestep, time-stamps them, and serialises one event per
// cycle (lowest index first) into a show-ahead FIFO. Spikes that collide with a pending event drop.
module spike_aer_encoder
    import aer_pkg::*;
#(
    parameter int unsigned N_NEURON   = 3,
    parameter int unsigned ADDR_W     = 2,
    parameter int unsigned TS_W       = 8,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_n,
    input  logic                        en_i,
    input  logic [N_NEURON-1:0]         spike_i,
    output logic                        evt_valid_o,
    input  logic                        evt_ready_i,
    output logic [ADDR_W-1:0]           evt_addr_o,
    output logic [TS_W-1:0]             evt_ts_o,
    output logic [clog2(FIFO_DEPTH):0]  fifo_lvl_o,
    output logic                        drop_o,
    output logic [DROP_CNT_W-1:0]       drop_cnt_o,
    input  logic                        clr_drop_i
);

    localparam int unsigned EVT_W = ADDR_W + TS_W;

    logic [TS_W-1:0]       ts_q, ts_d;
    logic [N_NEURON-1:0]   pend_q, pend_d;
    logic [TS_W-1:0]       pts_q [N_NEURON];
    logic [TS_W-1:0]       pts_d [N_NEURON];
    logic                  drop_q, drop_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [EVT_W-1:0]      fifo_head;

    logic [N_NEURON-1:0]   gnt_oh;
    logic                  gnt_valid;
    logic [ADDR_W-1:0]     gnt_addr;
    logic [TS_W-1:0]       gnt_ts;

    logic [N_NEURON-1:0]   spk_en;
    logic [N_NEURON-1:0]   cap;
    logic [N_NEURON-1:0]   drop_vec;
    logic [DROP_CNT_W:0]   n_drop;
    logic [DROP_CNT_W:0]   cnt_sum;

    // Fixed-priority arbiter; stalls entirely while the FIFO is full.
    always_comb begin
        gnt_oh    = '0;
        gnt_valid = 1'b0;
        gnt_addr  = '0;
        gnt_ts    = '0;
        for (int i = 0; i < N_NEURON; i++) begin
            if (!gnt_valid && pend_q[i] && !fifo_full) begin
                gnt_valid = 1'b1;
                gnt_oh[i] = 1'b1;
                gnt_addr  = ADDR_W'(i);
                gnt_ts    = pts_q[i];
            end
        end
    end

    always_comb begin
        spk_en   = en_i ? spike_i : '0;
        // A granted slot frees up this edge, so a new spike there is captured, not dropped.
        cap      = spk_en & (~pend_q | gnt_oh);
        drop_vec = spk_en & pend_q & ~gnt_oh;
        pend_d   = (pend_q & ~gnt_oh) | cap;
        ts_d     = en_i ? ts_q + TS_W'(1) : ts_q;
        n_drop   = '0;
        for (int i = 0; i < N_NEURON; i++) begin
            pts_d[i] = cap[i] ? ts_q : pts_q[i];
            n_drop   = n_drop + (DROP_CNT_W+1)'(drop_vec[i]);
        end
        cnt_sum    = {1'b0, clr_drop_i ? '0 : drop_cnt_q} + n_drop;
        drop_cnt_d = cnt_sum[DROP_CNT_W] ? '1 : cnt_sum[DROP_CNT_W-1:0];
        drop_d     = (drop_q && !clr_drop_i) || (|drop_vec);
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ts_q       <= '0;
            pend_q     <= '0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
            for (int i = 0; i < N_NEURON; i++) begin
                pts_q[i] <= '0;
            end
        end else begin
            ts_q       <= ts_d;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
            for (int i = 0; i < N_NEURON; i++) begin
                pts_q[i] <= pts_d[i];
            end
        end
    end

    aer_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .push_i      (gnt_valid),
        .push_data_i ({gnt_addr, gnt_ts}),
        .pop_i       (evt_ready_i),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_lvl_o)
    );

    always_comb begin
        evt_valid_o = !fifo_empty;
        evt_addr_o  = fifo_head[EVT_W-1:TS_W];
        evt_ts_o    = fifo_head[TS_W-1:0];
        drop_o      = drop_q;
        drop_cnt_o  = drop_cnt_q;
    end

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Self-checking bench for spike_aer_encoder: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a queue-based behavioural model.
module tb_spike_aer_encoder;
    import aer_pkg::*;

    localparam int unsigned N     = 3;
    localparam int unsigned AW    = 2;
    localparam int unsigned TW    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LW    = clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          rst_n = 1'b0;
    logic          en_i = 1'b0;
    logic [N-1:0]  spike_i = '0;
    logic          evt_ready_i = 1'b0;
    logic          clr_drop_i = 1'b0;
    logic          evt_valid_o;
    logic [AW-1:0] evt_addr_o;
    logic [TW-1:0] evt_ts_o;
    logic [LW-1:0] fifo_lvl_o;
    logic          drop_o;
    logic [7:0]    drop_cnt_o;

    spike_aer_encoder #(
        .N_NEURON   (N),
        .ADDR_W     (AW),
        .TS_W       (TW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .en_i        (en_i),
        .spike_i     (spike_i),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (evt_ready_i),
        .evt_addr_o  (evt_addr_o),
        .evt_ts_o    (evt_ts_o),
        .fifo_lvl_o  (fifo_lvl_o),
        .drop_o      (drop_o),
        .drop_cnt_o  (drop_cnt_o),
        .clr_drop_i  (clr_drop_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_on   = 1'b0;

    // Behavioural model state
    aer_evt_t m_q[$];
    bit       m_pend[N];
    int       m_pts[N];
    int       m_ts;
    bit       m_drop;
    int       m_cnt;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function void model_reset();
        m_q.delete();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_pts[i]  = 0;
        end
        m_ts   = 0;
        m_drop = 1'b0;
        m_cnt  = 0;
    endfunction

    function void model_step();
        int       g;
        int       nd;
        bit       capt[N];
        aer_evt_t e;
        g  = -1;
        nd = 0;
        if (m_q.size() < DEPTH) begin
            for (int i = 0; i < N; i++) begin
                if (m_pend[i]) begin
                    g = i;
                    break;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            capt[i] = 1'b0;
            if (en_i && spike_i[i]) begin
                if (m_pend[i] && i != g) nd++;
                else capt[i] = 1'b1;
            end
        end
        if (evt_ready_i && m_q.size() > 0) void'(m_q.pop_front());
        if (g >= 0) begin
            e.addr = AW'(g);
            e.ts   = TW'(m_pts[g]);
            m_q.push_back(e);
            m_pend[g] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (capt[i]) begin
                m_pend[i] = 1'b1;
                m_pts[i]  = m_ts;
            end
        end
        if (en_i) m_ts = (m_ts + 1) % 256;
        if (clr_drop_i) begin
            m_drop = (nd > 0);
            m_cnt  = (nd > 255) ? 255 : nd;
        end else begin
            if (nd > 0) m_drop = 1'b1;
            m_cnt = (m_cnt + nd > 255) ? 255 : m_cnt + nd;
        end
    endfunction

    always @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // Compare process: registered outputs are checked against the model every cycle.
    always @(negedge clk_i) begin
        if (rst_n && chk_on) begin
            chk("valid", int'(evt_valid_o), int'(m_q.size() > 0));
            chk("level", int'(fifo_lvl_o), m_q.size());
            chk("addr", int'(evt_addr_o), (m_q.size() > 0) ? int'(m_q[0].addr) : 0);
            chk("ts", int'(evt_ts_o), (m_q.size() > 0) ? int'(m_q[0].ts) : 0);
            chk("drop", int'(drop_o), int'(m_drop));
            chk("drop_cnt", int'(drop_cnt_o), m_cnt);
        end
    end

    task automatic cyc(input bit en, input logic [N-1:0] spk, input bit rdy, input bit clr);
        en_i        = en;
        spike_i     = spk;
        evt_ready_i = rdy;
        clr_drop_i  = clr;
        @(negedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        en_i        = 1'b0;
        spike_i     = '0;
        evt_ready_i = 1'b0;
        clr_drop_i  = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int n;
        int mode;
        do_reset();
        chk_on = 1'b1;
        chk("rst_valid", int'(evt_valid_o), 0);
        chk("rst_level", int'(fifo_lvl_o), 0);
        chk("rst_cnt", int'(drop_cnt_o), 0);

        // Single spike at ts=5
        repeat (5) cyc(1, 3'b000, 1, 0);
        cyc(1, 3'b010, 1, 0);
        chk("t1_lat1", int'(evt_valid_o), 0);
        cyc(1, 3'b000, 1, 0);
        chk("t1_valid", int'(evt_valid_o), 1);
        chk("t1_addr", int'(evt_addr_o), 1);
        chk("t1_ts", int'(evt_ts_o), 5);
        cyc(1, 3'b000, 1, 0);
        chk("t1_gone", int'(evt_valid_o), 0);

        // Burst at ts=0
        do_reset();
        cyc(1, 3'b111, 1, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 3'b000, 1, 0);
            chk("t2_valid", int'(evt_valid_o), 1);
            chk("t2_addr", int'(evt_addr_o), k);
            chk("t2_ts", int'(evt_ts_o), 0);
        end
        cyc(0, 3'b000, 1, 0);
        chk("t2_empty", int'(evt_valid_o), 0);

        // Backpressure: fill, one pending, three drops, then drain in ts order
        do_reset();
        repeat (12) cyc(1, 3'b001, 0, 0);
        chk("t3_level", int'(fifo_lvl_o), 8);
        chk("t3_cnt", int'(drop_cnt_o), 3);
        chk("t3_drop", int'(drop_o), 1);
        chk("t3_head", int'(evt_ts_o), 0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (evt_valid_o) begin
                chk("t3_order", int'(evt_ts_o), n);
                n++;
            end
            cyc(0, 3'b000, 1, 0);
        end
        chk("t3_count", n, 9);

        // Collision and clear, including clear coinciding with a drop
        do_reset();
        repeat (10) cyc(1, 3'b001, 0, 0);
        chk("t4_drop", int'(drop_o), 1);
        chk("t4_cnt", int'(drop_cnt_o), 1);
        cyc(0, 3'b000, 0, 1);
        chk("t4_clr_drop", int'(drop_o), 0);
        chk("t4_clr_cnt", int'(drop_cnt_o), 0);
        cyc(1, 3'b001, 0, 1);
        chk("t4_clrhit_drop", int'(drop_o), 1);
        chk("t4_clrhit_cnt", int'(drop_cnt_o), 1);
        cyc(0, 3'b000, 0, 1);

        // Timestamp wrap and enable gating
        do_reset();
        repeat (255) cyc(1, 3'b000, 1, 0);
        cyc(1, 3'b001, 1, 0);
        cyc(1, 3'b001, 1, 0);
        chk("t5_ts255", int'(evt_ts_o), 255);
        cyc(0, 3'b111, 1, 0);
        chk("t5_ts0", int'(evt_ts_o), 0);
        repeat (3) cyc(0, 3'b111, 1, 0);
        chk("t5_noevt", int'(evt_valid_o), 0);
        cyc(1, 3'b100, 1, 0);
        cyc(0, 3'b000, 1, 0);
        chk("t5_hold_addr", int'(evt_addr_o), 2);
        chk("t5_hold_ts", int'(evt_ts_o), 1);

        // Asynchronous reset mid-operation
        do_reset();
        repeat (4) cyc(1, 3'b111, 0, 0);
        cyc(1, 3'b000, 0, 0);
        chk("t6_level", int'(fifo_lvl_o), 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", int'(evt_valid_o), 0);
        chk("t6_rst_level", int'(fifo_lvl_o), 0);
        do_reset();
        repeat (6) cyc(0, 3'b000, 1, 0);
        chk("t6_stale", int'(evt_valid_o), 0);

        // Randomized run
        do_reset();
        mode = 0;
        for (int k = 0; k < 4000; k++) begin
            bit            en;
            bit            rdy;
            logic [N-1:0]  spk;
            if (k % 64 == 0) mode = int'($urandom_range(0, 2));
            en  = ($urandom_range(0, 3) != 0);
            spk = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom_range(0, 7));
            case (mode)
                0: rdy = 1'b1;
                1: rdy = ($urandom_range(0, 7) == 0);
                default: rdy = $urandom_range(0, 1) != 0;
            endcase
            cyc(en, spk, rdy, $urandom_range(0, 39) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
